// File: rtl/sc_fifo_ex.sv
// Single-clock FIFO with normal or show-ahead read, registered flags and sticky error flags.
// Define SC_FIFO_STAT_EN to add the peak_usedw high-water mark and its stat_clr input.
module sc_fifo_ex #(
    parameter int unsigned LOG2N      = 6,
    parameter int unsigned N          = (1 << LOG2N),
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHOWAHEAD  = 0,
    parameter int unsigned AF_LEVEL   = N - 4,
    parameter int unsigned AE_LEVEL   = 4
) (
    input  logic                  clock,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [DATA_WIDTH-1:0] q,
    output logic [LOG2N:0]        usedw,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
`ifdef SC_FIFO_STAT_EN
    ,
    input  logic                  stat_clr,
    output logic [LOG2N:0]        peak_usedw
`endif
);

    localparam int unsigned PW = LOG2N + 1;
    localparam logic [PW-1:0] Depth   = PW'(N);
    localparam logic [PW-1:0] AfLevel = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AeLevel = PW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [N];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         usedw_q, usedw_d;
    logic [DATA_WIDTH-1:0] q_q;
    logic                  full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
    logic                  empty_d;
    logic                  wr_acc, rd_acc, ram_rd;

    always_comb begin
        wr_acc   = wrreq && !full_q;
        rd_acc   = rdreq && !empty_q;
        wr_ptr_d = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d = rd_ptr_q + PW'(ram_rd);
        usedw_d  = usedw_q;
        case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + PW'(1);
            2'b01:   usedw_d = usedw_q - PW'(1);
            default: usedw_d = usedw_q;
        endcase
    end

    if (SHOWAHEAD != 0) begin : g_showahead
        // A word becomes fetchable one cycle after its write edge, so q shows it two edges later.
        logic [PW-1:0] wr_vis_q;

        always_ff @(posedge clock) begin
            if (sclr) begin
                wr_vis_q <= '0;
            end else begin
                wr_vis_q <= wr_ptr_q;
            end
        end

        // Refill the prefetch register whenever it is free or being acknowledged.
        assign ram_rd  = (rd_ptr_q != wr_vis_q) && (empty_q || rd_acc);
        assign empty_d = !(ram_rd || (!empty_q && !rd_acc));
    end else begin : g_normal
        assign ram_rd  = rd_acc;
        assign empty_d = (usedw_d == '0);
    end

    always_ff @(posedge clock) begin
        if (wr_acc && !sclr) begin
            mem[wr_ptr_q[LOG2N-1:0]] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            q_q <= '0;
        end else if (ram_rd) begin
            q_q <= mem[rd_ptr_q[LOG2N-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= (AeLevel != '0);
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            full_q   <= (usedw_d == Depth);
            empty_q  <= empty_d;
            af_q     <= (usedw_d >= AfLevel);
            ae_q     <= (usedw_d < AeLevel);
            ovf_q    <= ovf_q || (wrreq && full_q);
            unf_q    <= unf_q || (rdreq && empty_q);
        end
    end

`ifdef SC_FIFO_STAT_EN
    logic [PW-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (stat_clr) begin
            peak_d = usedw_d;
        end else if (usedw_d > peak_q) begin
            peak_d = usedw_d;
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_usedw = peak_q;
`endif

    assign q            = q_q;
    assign usedw        = usedw_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sc_fifo_ex.sv
// Bench for sc_fifo_ex: a normal-mode and a show-ahead instance share stimulus and are
// compared every cycle against queue-based models, plus hand-computed literal checks.
module tb_sc_fifo_ex;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       sclr, wrreq, rdreq;
    logic [7:0] data;
    logic [7:0] n_q, s_q;
    logic [4:0] n_usedw, s_usedw;
    logic       n_full, n_empty, n_af, n_ae, n_ovf, n_unf;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
`ifdef SC_FIFO_STAT_EN
    logic       stat_clr;
    logic [4:0] n_peak, s_peak;
    int         n_pk, s_pk;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sc_fifo_ex #(.LOG2N(4), .DATA_WIDTH(8), .SHOWAHEAD(0)) u_norm (
        .clock(clk), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(n_q), .usedw(n_usedw), .full(n_full), .empty(n_empty),
        .almost_full(n_af), .almost_empty(n_ae), .overflow(n_ovf), .underflow(n_unf)
`ifdef SC_FIFO_STAT_EN
        , .stat_clr(stat_clr), .peak_usedw(n_peak)
`endif
    );

    sc_fifo_ex #(.LOG2N(4), .DATA_WIDTH(8), .SHOWAHEAD(1)) u_sa (
        .clock(clk), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(s_q), .usedw(s_usedw), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_unf)
`ifdef SC_FIFO_STAT_EN
        , .stat_clr(stat_clr), .peak_usedw(s_peak)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference models: normal mode is a plain queue; show-ahead keeps write timestamps so a
    // word may be presented only once it is at least two edges old.
    typedef struct packed {
        logic [7:0] d;
        int         e;
    } ent_t;

    logic [7:0] nq[$];
    logic [7:0] n_qm = '0;
    bit         n_ovf_m, n_unf_m;
    ent_t       sq[$];
    bit         s_valid;
    logic [7:0] s_qm = '0;
    bit         s_ovf_m, s_unf_m;
    int         cyc = 0;
    bit         armed = 1'b0;

    always @(posedge clk) begin
        int   sz, su;
        ent_t e;
        if (sclr) begin
            nq.delete();
            n_qm = '0; n_ovf_m = 0; n_unf_m = 0;
            sq.delete();
            s_valid = 0; s_qm = '0; s_ovf_m = 0; s_unf_m = 0;
            armed = 1'b1;
        end else begin
            sz = nq.size();
            if (wrreq && sz == DEPTH) n_ovf_m = 1;
            if (rdreq && sz == 0) n_unf_m = 1;
            if (rdreq && sz > 0) n_qm = nq.pop_front();
            if (wrreq && sz < DEPTH) nq.push_back(data);

            su = sq.size() + int'(s_valid);
            if (wrreq && su == DEPTH) s_ovf_m = 1;
            if (rdreq && !s_valid) s_unf_m = 1;
            if (rdreq && s_valid) s_valid = 0;
            if (!s_valid && sq.size() > 0 && cyc - sq[0].e >= 2) begin
                e = sq.pop_front();
                s_qm = e.d;
                s_valid = 1;
            end
            if (wrreq && su < DEPTH) sq.push_back('{d: data, e: cyc});
        end
`ifdef SC_FIFO_STAT_EN
        su = sq.size() + int'(s_valid);
        if (sclr) begin
            n_pk = 0; s_pk = 0;
        end else begin
            if (stat_clr || nq.size() > n_pk) n_pk = nq.size();
            if (stat_clr || su > s_pk) s_pk = su;
        end
`endif
        cyc++;
    end

    always @(negedge clk) begin
        int su;
        if (armed) begin
            su = sq.size() + int'(s_valid);
            chk("n_usedw", 32'(n_usedw), 32'(nq.size()));
            chk("n_full", 32'(n_full), 32'(nq.size() == DEPTH));
            chk("n_empty", 32'(n_empty), 32'(nq.size() == 0));
            chk("n_almost_full", 32'(n_af), 32'(nq.size() >= 12));
            chk("n_almost_empty", 32'(n_ae), 32'(nq.size() < 4));
            chk("n_overflow", 32'(n_ovf), 32'(n_ovf_m));
            chk("n_underflow", 32'(n_unf), 32'(n_unf_m));
            chk("n_q", 32'(n_q), 32'(n_qm));
            chk("s_usedw", 32'(s_usedw), 32'(su));
            chk("s_full", 32'(s_full), 32'(su == DEPTH));
            chk("s_empty", 32'(s_empty), 32'(!s_valid));
            chk("s_almost_full", 32'(s_af), 32'(su >= 12));
            chk("s_almost_empty", 32'(s_ae), 32'(su < 4));
            chk("s_overflow", 32'(s_ovf), 32'(s_ovf_m));
            chk("s_underflow", 32'(s_unf), 32'(s_unf_m));
            chk("s_q", 32'(s_q), 32'(s_qm));
`ifdef SC_FIFO_STAT_EN
            chk("n_peak", 32'(n_peak), 32'(n_pk));
            chk("s_peak", 32'(s_peak), 32'(s_pk));
`endif
        end
    end

    task automatic step(input bit s, input bit w, input bit r, input logic [7:0] d);
        sclr  = s;
        wrreq = w;
        rdreq = r;
        data  = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int pw[4];
        int pr[4];
        pw = '{70, 30, 50, 90};
        pr = '{30, 70, 50, 90};
        sclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; data = '0;
`ifdef SC_FIFO_STAT_EN
        stat_clr = 1'b0;
`endif
        @(negedge clk);
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("rst_n_empty", 32'(n_empty), 32'd1);
        chk("rst_n_usedw", 32'(n_usedw), 32'd0);
        chk("rst_n_almost_empty", 32'(n_ae), 32'd1);
        chk("rst_n_q", 32'(n_q), 32'd0);
        chk("rst_s_empty", 32'(s_empty), 32'd1);

        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 8'(i));
            if (i == 10) chk("af_low_at_11", 32'(n_af), 32'd0);
            if (i == 11) chk("af_high_at_12", 32'(n_af), 32'd1);
        end
        chk("fill_full", 32'(n_full), 32'd1);
        chk("fill_usedw", 32'(n_usedw), 32'd16);
        chk("model_fill_size", 32'(nq.size()), 32'd16);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'h00);
        chk("drain_last_q", 32'(n_q), 32'h0F);
        chk("drain_empty", 32'(n_empty), 32'd1);
        chk("drain_usedw", 32'(n_usedw), 32'd0);

        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'h10 + i));
        step(0, 1, 1, 8'hEE);
        chk("ovf_usedw", 32'(n_usedw), 32'd15);
        chk("ovf_full", 32'(n_full), 32'd0);
        chk("ovf_flag", 32'(n_ovf), 32'd1);
        chk("ovf_q", 32'(n_q), 32'h10);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 8'h00);
        chk("ovf_data_intact", 32'(n_q), 32'h1F);
        step(1, 0, 0, 8'h00);
        chk("sclr_ovf", 32'(n_ovf), 32'd0);
        chk("sclr_usedw", 32'(n_usedw), 32'd0);
        chk("sclr_empty", 32'(n_empty), 32'd1);
        chk("sclr_q", 32'(n_q), 32'd0);

        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h20 + i));
        for (int i = 0; i < 100; i++) step(0, 1, 1, 8'(8'h28 + i));
        chk("wrap_usedw", 32'(n_usedw), 32'd8);
        chk("wrap_n_q", 32'(n_q), 32'h83);
        chk("wrap_s_q", 32'(s_q), 32'h84);
        chk("wrap_s_usedw", 32'(s_usedw), 32'd8);

        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        chk("unf_flag", 32'(n_unf), 32'd1);
        chk("unf_usedw", 32'(n_usedw), 32'd0);
        chk("unf_q_hold", 32'(n_q), 32'd0);
        chk("unf_s_flag", 32'(s_unf), 32'd1);
        step(1, 1, 0, 8'h77);
        chk("sclr_drops_wr", 32'(n_usedw), 32'd0);
        chk("sclr_drops_wr_empty", 32'(n_empty), 32'd1);

        step(0, 1, 0, 8'hA5);
        step(0, 0, 0, 8'h00);
        chk("sa_not_yet", 32'(s_empty), 32'd1);
        step(0, 0, 0, 8'h00);
        chk("sa_shown_empty", 32'(s_empty), 32'd0);
        chk("sa_shown_q", 32'(s_q), 32'hA5);
        step(0, 1, 0, 8'h5A);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        chk("sa_adv_q", 32'(s_q), 32'h5A);
        chk("sa_adv_empty", 32'(s_empty), 32'd0);
        step(0, 0, 1, 8'h00);
        chk("sa_drained", 32'(s_empty), 32'd1);
        chk("sa_drained_usedw", 32'(s_usedw), 32'd0);
        step(0, 0, 1, 8'h00);
        chk("sa_unf", 32'(s_unf), 32'd1);

`ifdef SC_FIFO_STAT_EN
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 8'(i));
        for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h00);
        chk("peak_10", 32'(n_peak), 32'd10);
        stat_clr = 1'b1;
        step(0, 0, 0, 8'h00);
        stat_clr = 1'b0;
        chk("peak_clr_3", 32'(n_peak), 32'd3);
`endif

        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(0, 63) == 0, $urandom_range(0, 99) < pw[seg],
                     $urandom_range(0, 99) < pr[seg], 8'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
